cp0_exc_ctrl: RTL and testbench

//  Coprocessor-0 exception/interrupt controller at the M stage; consumes exception flags raised upstream (ALU overflow, address, RI).

---
 rtl/cp0_pkg.sv | 54 +++++
 rtl/cp0_timer.sv | 35 +++
 rtl/cp0_exc_ctrl.sv | 100 ++++++++++
 tb/tb_cp0_exc_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values and SR/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int IM_LO     = 10;
  localparam int IM_HI     = 15;
  localparam int CAUSE_EXC = 2;
  localparam int CAUSE_BD  = 31;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] excCode;
  } cause_t;

  function automatic logic [31:0] packSr(sr_t s);
    logic [31:0] r;
    r = '0;
    r[IM_HI:IM_LO] = s.im;
    r[SR_EXL]      = s.exl;
    r[SR_IE]       = s.ie;
    return r;
  endfunction

  function automatic logic [31:0] packCause(cause_t c);
    logic [31:0] r;
    r = '0;
    r[CAUSE_BD]                  = c.bd;
    r[IM_HI:IM_LO]               = c.ip;
    r[CAUSE_EXC+4:CAUSE_EXC]     = c.excCode;
    return r;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with sticky match flag; only built when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wrEn,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timerPend
);

  logic wrCount, wrCompare;
  assign wrCount   = wrEn && (addr == REG_COUNT);
  assign wrCompare = wrEn && (addr == REG_COMPARE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      compare   <= '0;
      timerPend <= 1'b0;
    end else begin
      count <= wrCount ? wdata : count + 32'd1;
      if (wrCompare) compare <= wdata;
      // Rewriting Compare acknowledges the timer even if it matches this cycle.
      if (wrCompare)               timerPend <= 1'b0;
      else if (count == compare)   timerPend <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at M stage: SR/Cause/EPC/PRId, arbitration, mfc0/mtc0, eret.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h0000_2019,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic        exc_in,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        eret,
  output logic [31:0] rdata,
  output logic        req,
  output logic [31:0] epc,
  output logic [31:0] handler_pc,
  output logic        exl
);

  sr_t         sr;
  cause_t      cause;
  logic [31:0] epcReg;
  logic        intPend, excPend, wrEn;
  logic [31:0] countVal, compareVal;
  logic        timerPend;

  assign intPend    = (|(cause.ip & sr.im)) & sr.ie & ~sr.exl;
  assign excPend    = exc_in & ~sr.exl;
  assign req        = intPend | excPend;
  assign wrEn       = we & ~req;
  assign epc        = epcReg;
  assign exl        = sr.exl;
  assign handler_pc = HANDLER_PC;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .wrEn      (wrEn),
    .addr      (addr),
    .wdata     (wdata),
    .count     (countVal),
    .compare   (compareVal),
    .timerPend (timerPend)
  );
`else
  assign countVal   = '0;
  assign compareVal = '0;
  assign timerPend  = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so later statements in
  // this block see pre-edge values and the priority order below is purely by
  // statement position (mtc0, then eret, then req).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr     <= '0;
      cause  <= '0;
      epcReg <= '0;
    end else begin
      cause.ip <= {hw_int[5] | timerPend, hw_int[4:0]};
      if (wrEn && addr == REG_SR) begin
        sr.im  <= wdata[IM_HI:IM_LO];
        sr.exl <= wdata[SR_EXL];
        sr.ie  <= wdata[SR_IE];
      end
      if (wrEn && addr == REG_EPC) epcReg <= wdata;
      if (eret && sr.exl) sr.exl <= 1'b0;
      if (req) begin
        sr.exl        <= 1'b1;
        cause.excCode <= intPend ? EXC_INT : exc_code;
        cause.bd      <= bd_m;
        epcReg        <= bd_m ? pc_m - 32'd4 : pc_m;
      end
    end
  end

  // NOTE: rdata gets a default before the case so no path leaves it unassigned
  // (which would infer a latch); unmapped registers read as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      REG_SR:      rdata = packSr(sr);
      REG_CAUSE:   rdata = packCause(cause);
      REG_EPC:     rdata = epcReg;
      REG_PRID:    rdata = PRID;
      REG_COUNT:   rdata = countVal;
      REG_COMPARE: rdata = compareVal;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed scoreboard bench for cp0_exc_ctrl; timer steps run only when CP0_TIMER_EN is defined.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_in;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        eret;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] epc;
  logic [31:0] handler_pc;
  logic        exl;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  cp0_exc_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_in     (exc_in),
    .exc_code   (exc_code),
    .hw_int     (hw_int),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .eret       (eret),
    .rdata      (rdata),
    .req        (req),
    .epc        (epc),
    .handler_pc (handler_pc),
    .exl        (exl)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_val(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    compared++;
    assert (obs === e.val) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic clear_timer();
`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'hFFFF_FFFF);
`endif
  endtask

  initial begin
    logic [31:0] d;
    reset_n = 1'b0; pc_m = '0; bd_m = 1'b0; exc_in = 1'b0; exc_code = '0;
    hw_int = '0; we = 1'b0; addr = 5'd12; wdata = '0; eret = 1'b0;
    #2;

    // Reset state
    expect_val("rst_exl", 32'd0);        check_val({31'd0, exl});
    expect_val("rst_req", 32'd0);        check_val({31'd0, req});
    expect_val("rst_epc", 32'd0);        check_val(epc);
    expect_val("rst_sr", 32'd0);         read_reg(5'd12, d); check_val(d);
    expect_val("rst_prid", 32'h0000_2019); read_reg(5'd15, d); check_val(d);
    expect_val("handler_pc", 32'h0000_4180); check_val(handler_pc);

    #10; reset_n = 1'b1;
    step();
    clear_timer();

    // 1: interrupt taken
    mtc0(5'd12, 32'h0000_0401);
    expect_val("sr_write", 32'h0000_0401); read_reg(5'd12, d); check_val(d);
    hw_int = 6'b000001;
    step();
    pc_m = 32'h3000;
    expect_val("int_req", 32'd1); #1; check_val({31'd0, req});
    hw_int = '0;
    step();
    expect_val("int_epc", 32'h3000);  check_val(epc);
    expect_val("int_exl", 32'd1);     check_val({31'd0, exl});
    expect_val("int_req_off", 32'd0); check_val({31'd0, req});
    expect_val("int_cause", 32'd0);   read_reg(5'd13, d); check_val(d);

    // eret returns to NORMAL, epc stable
    eret = 1'b1;
    step();
    eret = 1'b0;
    expect_val("eret_exl", 32'd0);    check_val({31'd0, exl});
    expect_val("eret_epc", 32'h3000); check_val(epc);

    // 2: delay-slot overflow, then masked second exception
    exc_in = 1'b1; exc_code = 5'd12; bd_m = 1'b1; pc_m = 32'h3008;
    expect_val("exc_req", 32'd1); #1; check_val({31'd0, req});
    step();
    bd_m = 1'b0; exc_code = 5'd4; pc_m = 32'h5000;
    expect_val("exc_epc", 32'h3004);       check_val(epc);
    expect_val("exc_cause", 32'h8000_0030); read_reg(5'd13, d); check_val(d);
    expect_val("exc_masked_req", 32'd0);   check_val({31'd0, req});
    step();
    exc_in = 1'b0;
    expect_val("exc_masked_epc", 32'h3004);   check_val(epc);
    expect_val("exc_masked_cause", 32'h8000_0030); read_reg(5'd13, d); check_val(d);

    // mtc0 to SR together with eret: eret clears EXL, IM/IE from wdata
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0403; eret = 1'b1;
    step();
    we = 1'b0; eret = 1'b0;
    expect_val("eret_mtc0_sr", 32'h0000_0401); read_reg(5'd12, d); check_val(d);

    // 4: read-during-write on EPC, Cause write ignored, unmapped reads 0
    we = 1'b1; addr = 5'd14; wdata = 32'h3100;
    expect_val("rdw_old", 32'h3004); #1; check_val(rdata);
    step();
    we = 1'b0;
    expect_val("epc_write", 32'h3100); read_reg(5'd14, d); check_val(d);
    mtc0(5'd13, 32'hFFFF_FFFF);
    expect_val("cause_ro", 32'h8000_0030); read_reg(5'd13, d); check_val(d);
    expect_val("unmapped", 32'd0); read_reg(5'd20, d); check_val(d);

    // 3: interrupt beats exception; mtc0 suppressed in req cycle
    hw_int = 6'b000001;
    step();
    exc_in = 1'b1; exc_code = 5'd10; pc_m = 32'h3200;
    we = 1'b1; addr = 5'd14; wdata = 32'hABCD;
    hw_int = '0;
    expect_val("prio_req", 32'd1); #1; check_val({31'd0, req});
    step();
    we = 1'b0; exc_in = 1'b0;
    expect_val("prio_cause", 32'd0);  read_reg(5'd13, d); check_val(d);
    expect_val("prio_epc", 32'h3200); check_val(epc);
    expect_val("prio_exl", 32'd1);    check_val({31'd0, exl});

    // 5: async reset mid-handler
    #2; reset_n = 1'b0; #1;
    expect_val("arst_exl", 32'd0); check_val({31'd0, exl});
    expect_val("arst_req", 32'd0); check_val({31'd0, req});
    expect_val("arst_epc", 32'd0); check_val(epc);
    expect_val("arst_sr", 32'd0);  read_reg(5'd12, d); check_val(d);
    #10; reset_n = 1'b1;
    step();

`ifdef CP0_TIMER_EN
    // 6: Count/Compare timer interrupt on IP[15]
    begin
      bit got;
      got = 1'b0;
      mtc0(5'd9, 32'd0);
      mtc0(5'd11, 32'd5);
      mtc0(5'd12, 32'h0000_8001);
      for (int i = 0; i < 20 && !got; i++) begin
        if (req) got = 1'b1;
        else step();
      end
      expect_val("timer_req", 32'd1); check_val({31'd0, got});
      expect_val("timer_ip15", 32'd1); read_reg(5'd13, d); check_val({31'd0, d[15]});
      step();
      mtc0(5'd11, 32'd1000);
      step();
      expect_val("timer_clear", 32'd0); read_reg(5'd13, d); check_val({31'd0, d[15]});
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
